// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter slice.
package axis_pkg;

   localparam int AXIS_WIDTH = 16;
   localparam int AXIS_CNT_W = 16;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_LOCK0,
      ARB_LOCK1
   } arb_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer: the main register drives the outputs,
// and the skid register absorbs one beat while the main register is stalled.
module axis_skid_buffer #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             in_fire;

   // The skid slot only fills while the main register is full, so an empty
   // skid slot means fewer than two beats are held.
   assign in_ready = ~skid_valid;
   assign in_fire  = in_valid & in_ready;

   // Refill the main register whenever it is empty or draining, preferring
   // the older skid beat; otherwise park the incoming beat in the skid slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= in_fire;
            if (in_fire) begin
               out_data <= in_data;
            end
         end
      end else if (in_fire) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end

endmodule

// File: rtl/axis_pkt_arbiter_2to1.sv
// Two-input AXI-Stream arbiter, round-robin at packet granularity, feeding a
// registered skid buffer. Per-port completed-packet counters for status.
module axis_pkt_arbiter_2to1
   import axis_pkg::*;
#(
   parameter int WIDTH = AXIS_WIDTH,
   parameter int CNT_W = AXIS_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_0,
   input  logic             valid_0,
   input  logic             last_0,
   output logic             ready_0,
   input  logic [WIDTH-1:0] data_1,
   input  logic             valid_1,
   input  logic             last_1,
   output logic             ready_1,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             last,
   input  logic             ready,
   output logic [CNT_W-1:0] pkt_cnt_0,
   output logic [CNT_W-1:0] pkt_cnt_1
);

   arb_state_t       state, state_next;
   logic             prio, prio_next;
   logic             grant_valid;
   logic             grant_idx;
   logic             space;
   logic             sel_valid;
   logic             sel_last;
   logic [WIDTH-1:0] sel_data;
   logic             accept;
   logic [WIDTH:0]   buf_out;

   // Grant selection: a locked port keeps the grant; when idle, prio wins ties.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (prio ? valid_1 : valid_0) begin
               grant_valid = 1'b1;
               grant_idx   = prio;
            end else if (prio ? valid_0 : valid_1) begin
               grant_valid = 1'b1;
               grant_idx   = ~prio;
            end
         end
         ARB_LOCK0: begin
            grant_valid = 1'b1;
            grant_idx   = 1'b0;
         end
         ARB_LOCK1: begin
            grant_valid = 1'b1;
            grant_idx   = 1'b1;
         end
         default: begin
            grant_valid = 1'b0;
            grant_idx   = 1'b0;
         end
      endcase
   end

   assign ready_0   = space & grant_valid & ~grant_idx;
   assign ready_1   = space & grant_valid & grant_idx;
   assign sel_valid = grant_valid & (grant_idx ? valid_1 : valid_0);
   assign sel_last  = grant_idx ? last_1 : last_0;
   assign sel_data  = grant_idx ? data_1 : data_0;
   assign accept    = sel_valid & space;

   // Next-state: lock on a non-last beat from idle, release on any last beat.
   always_comb begin
      state_next = state;
      prio_next  = prio;
      if (accept) begin
         if (sel_last) begin
            state_next = ARB_IDLE;
            prio_next  = ~grant_idx;
         end else if (state == ARB_IDLE) begin
            state_next = grant_idx ? ARB_LOCK1 : ARB_LOCK0;
         end
      end
   end

   // Arbiter state and round-robin priority register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARB_IDLE;
         prio  <= 1'b0;
      end else begin
         state <= state_next;
         prio  <= prio_next;
      end
   end

   // Packet counters advance when the last beat is accepted upstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt_0 <= '0;
         pkt_cnt_1 <= '0;
      end else if (accept && sel_last) begin
         if (grant_idx) begin
            pkt_cnt_1 <= pkt_cnt_1 + CNT_W'(1);
         end else begin
            pkt_cnt_0 <= pkt_cnt_0 + CNT_W'(1);
         end
      end
   end

   axis_skid_buffer #(
      .WIDTH (WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sel_valid),
      .in_ready  (space),
      .in_data   ({sel_last, sel_data}),
      .out_valid (valid),
      .out_ready (ready),
      .out_data  (buf_out)
   );

   assign data = buf_out[WIDTH-1:0];
   assign last = buf_out[WIDTH];

endmodule

// File: tb/tb_axis_pkt_arbiter_2to1.sv
// Directed self-checking bench for the packet arbiter (CNT_W=4 to reach wrap).
module tb_axis_pkt_arbiter_2to1;
   import axis_pkg::*;

   typedef struct packed {
      logic        bubble;
      logic        last;
      logic [15:0] data;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] data_0, data_1, data;
   logic        valid_0, valid_1, valid;
   logic        last_0, last_1, last;
   logic        ready_0, ready_1, ready;
   logic [3:0]  pkt_cnt_0, pkt_cnt_1;

   beat_t       q0[$];
   beat_t       q1[$];
   logic [16:0] out_q[$];
   int          out_cyc[$];
   int          checks = 0;
   int          passed = 0;
   int          cyc = 0;
   int          acc0 = 0;
   int          bad_r1 = 0;
   int          non_idle = 0;
   bit          p0_done = 0;

   axis_pkt_arbiter_2to1 #(
      .WIDTH (16),
      .CNT_W (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_0    (data_0),
      .valid_0   (valid_0),
      .last_0    (last_0),
      .ready_0   (ready_0),
      .data_1    (data_1),
      .valid_1   (valid_1),
      .last_1    (last_1),
      .ready_1   (ready_1),
      .data      (data),
      .valid     (valid),
      .last      (last),
      .ready     (ready),
      .pkt_cnt_0 (pkt_cnt_0),
      .pkt_cnt_1 (pkt_cnt_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input int port, input logic [15:0] d, input logic l, input logic b);
      beat_t e;
      e.bubble = b;
      e.last   = l;
      e.data   = d;
      if (port == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic drive();
      valid_0 = 1'b0; last_0 = 1'b0; data_0 = '0;
      valid_1 = 1'b0; last_1 = 1'b0; data_1 = '0;
      if (q0.size() > 0) begin
         valid_0 = ~q0[0].bubble; last_0 = q0[0].last; data_0 = q0[0].data;
      end
      if (q1.size() > 0) begin
         valid_1 = ~q1[0].bubble; last_1 = q1[0].last; data_1 = q1[0].data;
      end
   endtask

   task automatic clear_tb();
      q0.delete(); q1.delete(); out_q.delete(); out_cyc.delete();
      acc0 = 0; bad_r1 = 0; non_idle = 0; p0_done = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_tb();
      drive();
      ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One clock: observe handshakes at the falling edge, advance sources after the rising edge.
   task automatic step();
      logic f0, f1;
      @(negedge clk);
      f0 = valid_0 && ready_0;
      f1 = valid_1 && ready_1;
      if (f0) acc0++;
      if (!p0_done && ready_1) bad_r1++;
      if (f0 && last_0) p0_done = 1;
      if (dut.state != ARB_IDLE) non_idle++;
      if (valid && ready) begin
         out_q.push_back({last, data});
         out_cyc.push_back(cyc);
      end
      cyc++;
      @(posedge clk);
      #1;
      if (q0.size() > 0 && (f0 || q0[0].bubble)) void'(q0.pop_front());
      if (q1.size() > 0 && (f1 || q1[0].bubble)) void'(q1.pop_front());
      drive();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ready = 1'b1;
      valid_0 = 1'b1; data_0 = 16'h00A1; last_0 = 1'b1;
      valid_1 = 1'b1; data_1 = 16'h01B1; last_1 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b expected 0", valid); else passed++;
      checks++; if (last !== 1'b0) $display("[TB] FAIL rst_last: got %b expected 0", last); else passed++;
      checks++; if (data !== 16'h0) $display("[TB] FAIL rst_data: got %h expected 0000", data); else passed++;
      checks++; if (pkt_cnt_0 !== 4'd0) $display("[TB] FAIL rst_cnt0: got %0d expected 0", pkt_cnt_0); else passed++;
      checks++; if (pkt_cnt_1 !== 4'd0) $display("[TB] FAIL rst_cnt1: got %0d expected 0", pkt_cnt_1); else passed++;
      checks++; if (ready_0 !== 1'b1) $display("[TB] FAIL rst_ready0: got %b expected 1", ready_0); else passed++;
      checks++; if (ready_1 !== 1'b0) $display("[TB] FAIL rst_ready1: got %b expected 0", ready_1); else passed++;
      rst_n = 1'b1;
      #1;
      checks++; if (valid !== 1'b0) $display("[TB] FAIL rel_valid: got %b expected 0", valid); else passed++;
      @(posedge clk); #1;
      checks++; if (valid !== 1'b1 || data !== 16'h00A1 || last !== 1'b1)
         $display("[TB] FAIL first_beat: got v%b l%b %h expected v1 l1 00A1", valid, last, data); else passed++;
      checks++; if (pkt_cnt_0 !== 4'd1) $display("[TB] FAIL first_cnt0: got %0d expected 1", pkt_cnt_0); else passed++;
      checks++; if (ready_1 !== 1'b1) $display("[TB] FAIL prio_flip: got %b expected 1", ready_1); else passed++;
      valid_0 = 1'b0;
      @(posedge clk); #1;
      valid_1 = 1'b0;
      checks++; if (data !== 16'h01B1 || pkt_cnt_1 !== 4'd1)
         $display("[TB] FAIL second_beat: got %h cnt1 %0d expected 01B1 cnt1 1", data, pkt_cnt_1); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [16:0] exp_b [12] = '{17'h00A00, 17'h00A01, 17'h10A02, 17'h01A00, 17'h01A01, 17'h11A02,
                                  17'h00B00, 17'h00B01, 17'h10B02, 17'h01B00, 17'h01B01, 17'h11B02};
      logic [16:0] got;
      int n;
      do_reset();
      for (int i = 0; i < 3; i++) push(0, 16'h0A00 + 16'(i), i == 2, 1'b0);
      for (int i = 0; i < 3; i++) push(0, 16'h0B00 + 16'(i), i == 2, 1'b0);
      for (int i = 0; i < 3; i++) push(1, 16'h1A00 + 16'(i), i == 2, 1'b0);
      for (int i = 0; i < 3; i++) push(1, 16'h1B00 + 16'(i), i == 2, 1'b0);
      drive();
      n = 0;
      while (out_q.size() < 12 && n < 40) begin step(); n++; end
      for (int i = 0; i < 12; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 17'bx;
         checks++; if (got !== exp_b[i]) $display("[TB] FAIL b2b_beat%0d: got %h expected %h", i, got, exp_b[i]); else passed++;
      end
      checks++;
      if (out_q.size() != 12 || (out_cyc[11] - out_cyc[0]) != 11)
         $display("[TB] FAIL b2b_rate: got %0d beats expected 12 in 12 consecutive cycles", out_q.size());
      else passed++;
      checks++; if (pkt_cnt_0 !== 4'd2 || pkt_cnt_1 !== 4'd2)
         $display("[TB] FAIL b2b_cnt: got %0d/%0d expected 2/2", pkt_cnt_0, pkt_cnt_1); else passed++;
   endtask

   task automatic test_lock_hold();
      logic [16:0] exp_l [5] = '{17'h00C00, 17'h00C01, 17'h00C02, 17'h10C03, 17'h11C00};
      logic [16:0] got;
      int n;
      do_reset();
      push(0, 16'h0C00, 1'b0, 1'b0);
      push(0, 16'h0C01, 1'b0, 1'b0);
      push(0, 16'h0000, 1'b0, 1'b1);
      push(0, 16'h0000, 1'b0, 1'b1);
      push(0, 16'h0C02, 1'b0, 1'b0);
      push(0, 16'h0C03, 1'b1, 1'b0);
      push(1, 16'h1C00, 1'b1, 1'b0);
      drive();
      n = 0;
      while (out_q.size() < 5 && n < 30) begin step(); n++; end
      for (int i = 0; i < 5; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 17'bx;
         checks++; if (got !== exp_l[i]) $display("[TB] FAIL lock_beat%0d: got %h expected %h", i, got, exp_l[i]); else passed++;
      end
      checks++; if (bad_r1 != 0) $display("[TB] FAIL lock_ready1: got %0d cycles high expected 0", bad_r1); else passed++;
   endtask

   task automatic test_backpressure();
      logic [16:0] got;
      int n;
      do_reset();
      for (int i = 0; i < 6; i++) push(0, 16'h0D00 + 16'(i), i == 5, 1'b0);
      drive();
      step();
      ready = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         checks++; if (ready_0 !== 1'b0 || valid !== 1'b1 || data !== 16'h0D00)
            $display("[TB] FAIL bp_stall%0d: got r%b v%b %h expected r0 v1 0D00", i, ready_0, valid, data); else passed++;
         step();
      end
      checks++; if (acc0 != 2) $display("[TB] FAIL bp_held: got %0d expected 2", acc0); else passed++;
      ready = 1'b1;
      n = 0;
      while (out_q.size() < 6 && n < 30) begin step(); n++; end
      for (int i = 0; i < 6; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 17'bx;
         checks++; if (got !== {i == 5, 16'h0D00 + 16'(i)})
            $display("[TB] FAIL bp_beat%0d: got %h expected %h", i, got, {i == 5, 16'h0D00 + 16'(i)}); else passed++;
      end
      step();
      checks++; if (out_q.size() != 6 || pkt_cnt_0 !== 4'd1)
         $display("[TB] FAIL bp_total: got %0d beats cnt %0d expected 6 beats cnt 1", out_q.size(), pkt_cnt_0); else passed++;
   endtask

   task automatic test_single_beat();
      logic [16:0] exp_s [8] = '{17'h10E00, 17'h11E00, 17'h10E01, 17'h11E01,
                                 17'h10E02, 17'h11E02, 17'h10E03, 17'h11E03};
      logic [16:0] got;
      int n;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(0, 16'h0E00 + 16'(i), 1'b1, 1'b0);
         push(1, 16'h1E00 + 16'(i), 1'b1, 1'b0);
      end
      drive();
      n = 0;
      while (out_q.size() < 8 && n < 30) begin step(); n++; end
      for (int i = 0; i < 8; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 17'bx;
         checks++; if (got !== exp_s[i]) $display("[TB] FAIL single_beat%0d: got %h expected %h", i, got, exp_s[i]); else passed++;
      end
      checks++; if (out_q.size() != 8 || (out_cyc[7] - out_cyc[0]) != 7)
         $display("[TB] FAIL single_rate: got %0d beats expected 8 consecutive", out_q.size()); else passed++;
      checks++; if (non_idle != 0) $display("[TB] FAIL single_idle: got %0d non-idle cycles expected 0", non_idle); else passed++;
      checks++; if (pkt_cnt_0 !== 4'd4 || pkt_cnt_1 !== 4'd4)
         $display("[TB] FAIL single_cnt: got %0d/%0d expected 4/4", pkt_cnt_0, pkt_cnt_1); else passed++;
   endtask

   task automatic test_reset_midpacket_wrap();
      int n;
      do_reset();
      push(0, 16'h0F10, 1'b1, 1'b0);
      push(0, 16'h0F00, 1'b0, 1'b0);
      push(0, 16'h0F01, 1'b0, 1'b0);
      push(0, 16'h0F02, 1'b1, 1'b0);
      drive();
      step();
      step();
      checks++; if (valid !== 1'b1 || data !== 16'h0F00 || pkt_cnt_0 !== 4'd1)
         $display("[TB] FAIL mid_pre: got v%b %h cnt %0d expected v1 0F00 cnt 1", valid, data, pkt_cnt_0); else passed++;
      ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (valid !== 1'b0 || data !== 16'h0 || last !== 1'b0)
         $display("[TB] FAIL mid_async: got v%b l%b %h expected v0 l0 0000", valid, last, data); else passed++;
      checks++; if (pkt_cnt_0 !== 4'd0) $display("[TB] FAIL mid_cnt0: got %0d expected 0", pkt_cnt_0); else passed++;
      clear_tb();
      drive();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      checks++; if (dut.state !== ARB_IDLE) $display("[TB] FAIL mid_state: got %0d expected %0d", dut.state, ARB_IDLE); else passed++;
      checks++; if (dut.prio !== 1'b0) $display("[TB] FAIL mid_prio: got %b expected 0", dut.prio); else passed++;
      for (int i = 0; i < 16; i++) push(0, 16'h0100 + 16'(i), 1'b1, 1'b0);
      ready = 1'b1;
      drive();
      n = 0;
      while (out_q.size() < 16 && n < 60) begin step(); n++; end
      checks++; if (out_q.size() != 16 || out_q[15] !== 17'h1010F)
         $display("[TB] FAIL wrap_beats: got %0d beats expected 16 ending 1010F", out_q.size()); else passed++;
      checks++; if (pkt_cnt_0 !== 4'd0 || pkt_cnt_1 !== 4'd0)
         $display("[TB] FAIL wrap_cnt: got %0d/%0d expected 0/0", pkt_cnt_0, pkt_cnt_1); else passed++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_lock_hold();
      test_backpressure();
      test_single_beat();
      test_reset_midpacket_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/axis_pkt_arbiter_2to1.md
# axis_pkt_arbiter_2to1

Packet-aware two-input AXI-Stream arbiter that sits directly upstream of the output stage and merges two producer streams into one. Arbitration is round-robin at packet granularity: once a port is granted, that port holds the grant until its `last` beat transfers. The merged stream leaves through a registered skid buffer, so every output is registered and full throughput is sustained under back-pressure. Per-port completed-packet counters are provided for status and debug.

## Interface
- `WIDTH`, 16, data width of all stream ports.
- `CNT_W`, 16, width of each packet counter.

- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_0`  in  WIDTH  port 0 payload.
- `valid_0`  in  1  port 0 beat valid.
- `last_0`  in  1  port 0 end-of-packet marker.
- `ready_0`  out  1  port 0 beat accepted when `valid_0 && ready_0`.
- `data_1`, `valid_1`, `last_1`, `ready_1`: port 1, same widths and meaning as port 0.
- `data`  out  WIDTH  merged payload, registered.
- `valid`  out  1  merged beat valid, registered.
- `last`  out  1  merged end-of-packet, registered.
- `ready`  in  1  downstream accept.
- `pkt_cnt_0`  out  CNT_W  number of port 0 packets accepted (`last_0` beats).
- `pkt_cnt_1`  out  CNT_W  number of port 1 packets accepted (`last_1` beats).

## Operation
- State machine `ARB_IDLE`, `ARB_LOCK0`, `ARB_LOCK1`. Priority register `prio` (0 or 1).
- `space` is true while the skid buffer holds fewer than 2 beats, i.e. while its internal ready is high.
- In `ARB_IDLE`, the grant goes to port `prio` if that port's valid is high; otherwise to the other port if its valid is high; otherwise there is no grant.
- `ready_k = space && grant==k`. In `ARB_IDLE`, ready therefore depends combinationally on valid. This is permitted; valid never depends on ready.
- On an accepted beat from port k:
  - Non-last beat in `ARB_IDLE`: go to `ARB_LOCKk`.
  - Last beat, from any state: go to `ARB_IDLE`, set `prio = ~k`, and increment `pkt_cnt_k` (wraps modulo 2^CNT_W).
  - Single-beat packets are accepted in `ARB_IDLE` without entering a lock state.
- In `ARB_LOCKk`, only port k is granted. The other port's ready stays 0 even while port k is idle mid-packet.
- Beats are forwarded unmodified: data, last, and order within a port are preserved. Packets from the two ports are never interleaved.
- Skid buffer behaviour:
  - The main register drives the outputs.
  - The skid register captures one beat arriving while the main register is stalled.
  - When the main register drains, the skid beat moves into it.
- Reset, including mid-packet:
  - State returns to `ARB_IDLE`, `prio` to 0, and both counters to 0.
  - Buffered beats are discarded.
  - The upstream producer is responsible for restarting the packet.

## Timing
- Reset values:
  - `valid`=0, `last`=0, `data`=0, `pkt_cnt_0`=0, `pkt_cnt_1`=0.
  - `ready_0`/`ready_1` follow the grant equation (space=1 after reset), so they are 0 while the corresponding valid is low.
- Latency: a beat accepted at edge N is presented on `data`/`valid`/`last` after edge N, i.e. one cycle later.
- Throughput: one beat per cycle with `ready` held high, including back-to-back packets from alternating ports. There is no idle cycle at a packet boundary.
- Back-pressure: with `ready`=0 and the main register full, one further beat is absorbed into the skid register. `space` then drops on the following cycle. At most 2 beats are ever held.
- If the input accept and output drain happen in the same cycle, occupancy is unchanged.
- The counter increments on the edge that accepts the last beat, not when the last beat leaves the output.
- Simultaneous `valid_0` and `valid_1` in `ARB_IDLE`: `prio` decides the grant, and the loser waits for the winner's last beat.

## Structure
- Shared package `axis_pkg`:
  - `arb_state_t` enum {`ARB_IDLE`, `ARB_LOCK0`, `ARB_LOCK1`}.
  - Default width constants for WIDTH/CNT_W.
- One sub-module, `axis_skid_buffer` (params WIDTH+1 to carry last with the data). It provides in_valid/in_ready/in_data and out_valid/out_ready/out_data, on the same `clk`/`rst_n`.
- The arbiter FSM, grant logic and counters live in the top module.

## Test plan
- Reset with `valid_0`=`valid_1`=1 -> after release, port 0 is granted first (`prio`=0); first output beat appears 1 cycle after acceptance; both counters read 0 during reset.
- Both ports send 3-beat packets continuously with `ready`=1 -> output order P0,P1,P0,P1; no interleaving; one beat per cycle; counters increase by 1 per packet each.
- Port 0 packet of 4 beats, with `valid_0` low for 2 cycles after beat 2 while `valid_1`=1 -> `ready_1` stays 0 throughout; port 1 is granted only after port 0's last beat.
- `ready`=0 for 5 cycles during a packet -> exactly 2 beats buffered; `ready_0` drops on the cycle after the skid fills; after `ready` returns, no data is lost or duplicated.
- Single-beat packets (`last`=1 every beat) on both ports -> alternating grant every cycle; state never leaves `ARB_IDLE`.
- Assert `rst_n`=0 mid-packet with 1 beat buffered -> `valid` drops to 0 immediately (asynchronous); after release, the FSM is in `ARB_IDLE` with `prio`=0 and counters at 0; with CNT_W=4, 16 packets wrap `pkt_cnt_0` to 0.
